// File: rtl/fpdiv_pkg.sv
// Shared constants and FSM state type for the shift-subtract fixed-point divider.
package fpdiv_pkg;

  localparam int unsigned DEF_WIDTH = 10;
  localparam int unsigned DEF_ITERS = 14;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_INIT = 3'd2,
    S_ITER = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/fpdiv_iter_cnt.sv
// Iteration counter: synchronous clear, enable, saturates at LAST and flags it.
module fpdiv_iter_cnt #(
  parameter int unsigned CNT_W = fpdiv_pkg::DEF_CNT_W,
  parameter int unsigned LAST  = fpdiv_pkg::DEF_ITERS - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == CNT_W'(LAST));

  // Holding at LAST keeps the index inside the legal iteration range.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fixed_point_div_ctrl.sv
// Controller for a restoring shift-subtract divider: sequences load, init,
// ITERS shift/subtract steps and a completion pulse, with sticky status flags.
module fixed_point_div_ctrl
  import fpdiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned ITERS = DEF_ITERS,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             b_zero,
  input  logic             gt,
  input  logic             ov_in,
  output logic             ld_a,
  output logic             ld_b,
  output logic             acc_init,
  output logic             shift,
  output logic             acc_sub,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             dvz,
  output logic             ovf,
  output state_t           fsm_state
);

  localparam bit PARAMS_OK = (WIDTH > 0) && (ITERS > 0) && ((2 ** CNT_W) >= ITERS);

  if (!PARAMS_OK) begin : g_params_bad
    $error("fixed_point_div_ctrl: illegal WIDTH/ITERS/CNT_W combination");
  end

  // Handshake: start is a level sampled only in IDLE; anything else is dropped.
  state_t state, state_next;
  logic   cnt_clr, cnt_en, cnt_tc;
  logic   accept;

  assign fsm_state = state;
  assign accept    = (state == S_IDLE) && start;

  fpdiv_iter_cnt #(
    .CNT_W (CNT_W),
    .LAST  (ITERS - 1)
  ) u_iter_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    acc_init   = 1'b0;
    shift      = 1'b0;
    acc_sub    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        ld_a       = 1'b1;
        ld_b       = 1'b1;
        busy       = 1'b1;
        state_next = S_INIT;
      end
      S_INIT: begin
        acc_init   = 1'b1;
        busy       = 1'b1;
        cnt_clr    = 1'b1;
        state_next = b_zero ? S_DONE : S_ITER;
      end
      S_ITER: begin
        shift   = 1'b1;
        acc_sub = gt;
        busy    = 1'b1;
        // Overflow aborts regardless of how many steps remain.
        cnt_en  = !ov_in;
        if (ov_in || cnt_tc) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      dvz <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (state == S_INIT && b_zero) dvz <= 1'b1;
      if (state == S_ITER && ov_in)  ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fixed_point_div_ctrl.sv
// Randomized bench for fixed_point_div_ctrl against a per-run timeline model.
module tb_fixed_point_div_ctrl;
  import fpdiv_pkg::*;

  localparam int ITERS = 14;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, start, b_zero, gt, ov_in;
  logic ld_a, ld_b, acc_init, shift, acc_sub, busy, done, dvz, ovf;
  logic [CNT_W-1:0] cnt;
  state_t fsm_state;
  logic [6:0] outs;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_dvz   = 1'b0;
  bit m_ovf   = 1'b0;

  fixed_point_div_ctrl #(.WIDTH(10), .ITERS(ITERS), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .b_zero    (b_zero),
    .gt        (gt),
    .ov_in     (ov_in),
    .ld_a      (ld_a),
    .ld_b      (ld_b),
    .acc_init  (acc_init),
    .shift     (shift),
    .acc_sub   (acc_sub),
    .cnt       (cnt),
    .busy      (busy),
    .done      (done),
    .dvz       (dvz),
    .ovf       (ovf),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  assign outs = {ld_a, ld_b, acc_init, shift, acc_sub, busy, done};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected strobes for cycle k after an accepted start, finishing at cycle fin.
  function automatic logic [6:0] exp_outs(input int k, input int fin, input bit bz, input logic g);
    logic ld, ai, sh, as_, bs, dn;
    ld  = (k == 1);
    ai  = (k == 2);
    sh  = !bz && (k >= 3) && (k < fin);
    as_ = sh && g;
    bs  = (k >= 1) && (k < fin);
    dn  = (k == fin);
    return {ld, ld, ai, sh, as_, bs, dn};
  endfunction

  function automatic int run_len(input bit bz, input int ov_at);
    if (bz) return 3;
    if (ov_at >= 0) return 4 + ov_at;
    return ITERS + 3;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      b_zero = 1'($urandom_range(0, 1)); gt = 1'($urandom_range(0, 1));
      ov_in = 1'($urandom_range(0, 1));
      #1;
      check("idle_outs", 32'(outs), 32'd0);
      check("idle_dvz", 32'(dvz), 32'(m_dvz));
      check("idle_ovf", 32'(ovf), 32'(m_ovf));
    end
  endtask

  // One division from the IDLE cycle in which start is raised.
  task automatic run_div(input bit bz, input int ov_at, input bit hold_start,
                         input bit noisy, input int rst_at);
    int fin;
    fin = run_len(bz, ov_at);
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    b_zero = 1'($urandom_range(0, 1)); gt = 1'($urandom_range(0, 1));
    ov_in = 1'($urandom_range(0, 1));
    #1;
    check("accept_outs", 32'(outs), 32'd0);
    check("accept_dvz_held", 32'(dvz), 32'(m_dvz));
    check("accept_ovf_held", 32'(ovf), 32'(m_ovf));
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      rst    = (k == rst_at);
      start  = (hold_start || k == rst_at) ? 1'b1 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
      gt     = 1'($urandom_range(0, 1));
      b_zero = (k == 2) ? bz : 1'($urandom_range(0, 1));
      ov_in  = (k >= 3 && k < fin) ? (k == 3 + ov_at) : 1'($urandom_range(0, 1));
      #1;
      check("run_outs", 32'(outs), 32'(exp_outs(k, fin, bz, gt)));
      if (k >= 3 && k < fin) check("iter_cnt", 32'(cnt), 32'(k - 3));
      if (k < fin) begin
        check("run_dvz_clear", 32'(dvz), 32'd0);
        check("run_ovf_clear", 32'(ovf), 32'd0);
      end else begin
        check("done_dvz", 32'(dvz), 32'(bz));
        check("done_ovf", 32'(ovf), 32'(!bz && ov_at >= 0));
      end
      if (k == rst_at) begin
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        check("rst_outs", 32'(outs), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_dvz", 32'(dvz), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        m_dvz = 1'b0;
        m_ovf = 1'b0;
        return;
      end
    end
    m_dvz = bz;
    m_ovf = !bz && (ov_at >= 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; b_zero = 1'b0; gt = 1'b0; ov_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_cnt", 32'(cnt), 32'd0);
    check("reset_dvz", 32'(dvz), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    idle_cycles(3);

    run_div(1'b0, -1, 1'b0, 1'b0, 0);  // normal 17-cycle division
    idle_cycles(2);
    run_div(1'b1, -1, 1'b0, 1'b0, 0);  // divide by zero
    idle_cycles(3);
    run_div(1'b0, 5, 1'b0, 1'b0, 0);   // overflow at cnt=5
    idle_cycles(2);
    run_div(1'b0, -1, 1'b0, 1'b1, 0);  // start noise while busy/done
    idle_cycles(1);
    run_div(1'b0, -1, 1'b0, 1'b1, 10); // reset at cnt=7, start asserted with it
    idle_cycles(1);
    run_div(1'b0, -1, 1'b0, 1'b0, 0);  // fresh run after reset
    run_div(1'b1, -1, 1'b1, 1'b0, 0);  // back-to-back, start held
    run_div(1'b0, 13, 1'b1, 1'b0, 0);
    run_div(1'b0, -1, 1'b1, 1'b0, 0);
    idle_cycles(2);

    for (int r = 0; r < 30; r++) begin
      bit bz, hold;
      int ov_at, fin, rst_at;
      bz    = ($urandom_range(0, 3) == 0);
      ov_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ITERS - 1)) : -1;
      hold  = 1'($urandom_range(0, 1));
      fin   = run_len(bz, ov_at);
      rst_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, fin - 1)) : 0;
      run_div(bz, ov_at, hold, 1'b1, rst_at);
      if (!hold || rst_at != 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
